// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM states, the ID/EX control
// bundle and the bubble constant loaded whenever an instruction is squashed or held.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } state_t;

  localparam int unsigned REG_W_DEF = 4;

  typedef struct packed {
    logic valid;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic immd;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Decode/hazard-side handshake and ID/EX outputs of the stall controller.
// master = decode/hazard side, slave = pipe_stall_ctrl.
interface pipe_stall_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned CNT_W = 16
);
  logic             StallReq;
  logic             BranchTaken;
  logic             IDValid;
  logic             IDMemRead;
  logic             IDMemWrite;
  logic             IDRegWrite;
  logic             IDImmd;
  logic [REG_W-1:0] IDRegOp1;
  logic [REG_W-1:0] IDRegOp2;

  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXValid;
  logic             IDEXMemRead;
  logic             IDEXMemWrite;
  logic             IDEXRegWrite;
  logic             IDEXImmd;
  logic [REG_W-1:0] IDEXRegOp1;
  logic [REG_W-1:0] IDEXRegOp2;
  logic             StallErr;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] BubbleCount;

  modport master (
    output StallReq, BranchTaken, IDValid, IDMemRead, IDMemWrite, IDRegWrite, IDImmd,
           IDRegOp1, IDRegOp2,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXValid, IDEXMemRead, IDEXMemWrite,
           IDEXRegWrite, IDEXImmd, IDEXRegOp1, IDEXRegOp2, StallErr, StallCount, BubbleCount
  );

  modport slave (
    input  StallReq, BranchTaken, IDValid, IDMemRead, IDMemWrite, IDRegWrite, IDImmd,
           IDRegOp1, IDRegOp2,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXValid, IDEXMemRead, IDEXMemWrite,
           IDEXRegWrite, IDEXImmd, IDEXRegOp1, IDEXRegOp2, StallErr, StallCount, BubbleCount
  );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: PC/IF-ID enables, ID/EX control register with bubbles,
// stall watchdog. Optional perf counters behind `PIPE_STALL_PERF_CNT_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W        = REG_W_DEF,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL    = 8,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_stall_ctrl_if.slave  bus
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_LIMIT  = 8'(MAX_STALL);
  localparam logic [7:0] STALL_ERR_AT = 8'(MAX_STALL - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_flush_cnt;
  logic [2:0]       w_flush_cnt_nxt;
  logic             w_flush;
  logic             w_stall;
  ctrl_t            w_id_ctrl;
  ctrl_t            r_idex_ctrl;
  logic [REG_W-1:0] r_idex_op1;
  logic [REG_W-1:0] r_idex_op2;
  logic [7:0]       w_stall_run;
  logic             r_stall_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Branch beats everything; in FLUSH a stall request is ignored.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_flush         = 1'b0;
    w_stall         = 1'b0;
    if (bus.BranchTaken) begin
      w_flush         = 1'b1;
      w_flush_cnt_nxt = FLUSH_RELOAD;
      w_state_nxt     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else begin
      case (r_state)
        FLUSH: begin
          w_flush         = 1'b1;
          w_flush_cnt_nxt = (r_flush_cnt == 3'd0) ? 3'd0 : r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1) w_state_nxt = RUN;
        end
        default: begin
          if (bus.StallReq) begin
            w_stall     = 1'b1;
            w_state_nxt = STALL;
          end else begin
            w_state_nxt = RUN;
          end
        end
      endcase
    end
  end

  assign bus.PCWrite   = rst_n & ~w_stall;
  assign bus.IFIDWrite = rst_n & ~w_stall;
  assign bus.IFIDFlush = rst_n & w_flush;

  always_comb begin
    w_id_ctrl = '{valid:     bus.IDValid,
                  mem_read:  bus.IDMemRead,
                  mem_write: bus.IDMemWrite,
                  reg_write: bus.IDRegWrite,
                  immd:      bus.IDImmd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex_ctrl <= BUBBLE_CTRL;
      r_idex_op1  <= '0;
      r_idex_op2  <= '0;
    end else if (w_flush || w_stall) begin
      r_idex_ctrl <= BUBBLE_CTRL;
      r_idex_op1  <= '0;
      r_idex_op2  <= '0;
    end else begin
      r_idex_ctrl <= w_id_ctrl;
      r_idex_op1  <= bus.IDRegOp1;
      r_idex_op2  <= bus.IDRegOp2;
    end
  end

  assign bus.IDEXValid    = r_idex_ctrl.valid;
  assign bus.IDEXMemRead  = r_idex_ctrl.mem_read;
  assign bus.IDEXMemWrite = r_idex_ctrl.mem_write;
  assign bus.IDEXRegWrite = r_idex_ctrl.reg_write;
  assign bus.IDEXImmd     = r_idex_ctrl.immd;
  assign bus.IDEXRegOp1   = r_idex_op1;
  assign bus.IDEXRegOp2   = r_idex_op2;

  sat_counter #(
    .WIDTH (8),
    .MAX   (STALL_LIMIT)
  ) u_stall_run (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall),
    .i_clr (~w_stall),
    .o_cnt (w_stall_run)
  );

  // Sets on the edge where the run count reaches MAX_STALL, i.e. it currently holds MAX_STALL-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_err <= 1'b0;
    end else if (w_stall && (w_stall_run >= STALL_ERR_AT)) begin
      r_stall_err <= 1'b1;
    end
  end

  assign bus.StallErr = r_stall_err;

`ifdef PIPE_STALL_PERF_CNT_EN
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall),
    .i_clr (1'b0),
    .o_cnt (bus.StallCount)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall | w_flush),
    .i_clr (1'b0),
    .o_cnt (bus.BubbleCount)
  );
`else
  assign bus.StallCount  = {CNT_W{1'b0}};
  assign bus.BubbleCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed table, hand sequences, random vs model.
module tb_pipe_stall_ctrl;

  localparam int unsigned RW    = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned FC    = 2;
  localparam int unsigned MAXS  = 8;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pipe_stall_ctrl_if #(.REG_W(RW), .CNT_W(CW)) bus ();

  pipe_stall_ctrl #(
    .REG_W        (RW),
    .FLUSH_CYCLES (FC),
    .MAX_STALL    (MAXS),
    .CNT_W        (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned m_flush_left;
  int unsigned m_stall_run;
  logic        m_err;
  int unsigned m_scnt;
  int unsigned m_bcnt;
  logic [4:0]  m_ctrl;
  logic [3:0]  m_op1;
  logic [3:0]  m_op2;
  logic        c_pcw;
  logic        c_flush;

  task automatic model_reset();
    m_flush_left = 0;
    m_stall_run  = 0;
    m_err        = 1'b0;
    m_scnt       = 0;
    m_bcnt       = 0;
    m_ctrl       = '0;
    m_op1        = '0;
    m_op2        = '0;
  endtask

  task automatic model_edge(input logic st, input logic br, input logic v,
                            input logic [3:0] ctrl, input logic [3:0] op1, input logic [3:0] op2);
    bit flushing, stalling;
    flushing = br || (m_flush_left > 0);
    stalling = !flushing && st;
    if (flushing || stalling) begin
      m_ctrl = '0; m_op1 = '0; m_op2 = '0;
      if (m_bcnt < CMAX) m_bcnt++;
    end else begin
      m_ctrl = {v, ctrl}; m_op1 = op1; m_op2 = op2;
    end
    if (flushing) m_flush_left = br ? FC - 1 : m_flush_left - 1;
    if (stalling) begin
      m_stall_run = (m_stall_run + 1 > MAXS) ? MAXS : m_stall_run + 1;
      if (m_stall_run == MAXS) m_err = 1'b1;
      if (m_scnt < CMAX) m_scnt++;
    end else begin
      m_stall_run = 0;
    end
  endtask

  function automatic int unsigned perf(input int unsigned v);
`ifdef PIPE_STALL_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_ctrl();
    return {bus.IDEXValid, bus.IDEXMemRead, bus.IDEXMemWrite, bus.IDEXRegWrite, bus.IDEXImmd};
  endfunction

  task automatic chk_regs();
    chk("idex_ctrl", 32'(dut_ctrl()), 32'(m_ctrl));
    chk("idex_op1", 32'(bus.IDEXRegOp1), 32'(m_op1));
    chk("idex_op2", 32'(bus.IDEXRegOp2), 32'(m_op2));
    chk("stall_err", 32'(bus.StallErr), 32'(m_err));
    chk("stall_count", 32'(bus.StallCount), perf(m_scnt));
    chk("bubble_count", 32'(bus.BubbleCount), perf(m_bcnt));
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input logic st, input logic br, input logic v,
                      input logic [3:0] ctrl, input logic [3:0] op1, input logic [3:0] op2);
    bit flushing;
    bus.StallReq    = st;
    bus.BranchTaken = br;
    bus.IDValid     = v;
    {bus.IDMemRead, bus.IDMemWrite, bus.IDRegWrite, bus.IDImmd} = ctrl;
    bus.IDRegOp1    = op1;
    bus.IDRegOp2    = op2;
    #4;
    flushing = br || (m_flush_left > 0);
    c_pcw    = bus.PCWrite;
    c_flush  = bus.IFIDFlush;
    chk("pcwrite", 32'(bus.PCWrite), 32'(flushing || !st));
    chk("ifidwrite", 32'(bus.IFIDWrite), 32'(flushing || !st));
    chk("ifidflush", 32'(bus.IFIDFlush), 32'(flushing));
    @(posedge clk);
    model_edge(st, br, v, ctrl, op1, op2);
    #1;
    chk_regs();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        st, br, v;
    logic [3:0]  ctrl, op1, op2;
    logic        exp_pcw, exp_flush;
    logic [4:0]  exp_ctrl;
    logic [3:0]  exp_op1, exp_op2;
    int unsigned exp_scnt, exp_bcnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{0,0,1, 4'b0010, 4'd3, 4'd1,  1,0, 5'b10010, 4'd3, 4'd1,  0,0};
    tbl[1] = '{1,0,1, 4'b1010, 4'd4, 4'd5,  0,0, 5'b00000, 4'd0, 4'd0,  1,1};
    tbl[2] = '{0,0,1, 4'b1010, 4'd4, 4'd5,  1,0, 5'b11010, 4'd4, 4'd5,  1,1};
    tbl[3] = '{1,1,1, 4'b0101, 4'd6, 4'd7,  1,1, 5'b00000, 4'd0, 4'd0,  1,2};
    tbl[4] = '{1,0,1, 4'b0101, 4'd6, 4'd7,  1,1, 5'b00000, 4'd0, 4'd0,  1,3};
    tbl[5] = '{0,0,0, 4'b1111, 4'd2, 4'd2,  1,0, 5'b01111, 4'd2, 4'd2,  1,3};
    tbl[6] = '{0,0,1, 4'b0011, 4'd9, 4'd10, 1,0, 5'b10011, 4'd9, 4'd10, 1,3};
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.StallReq = 1'b0; bus.BranchTaken = 1'b0; bus.IDValid = 1'b0;
    bus.IDMemRead = 1'b0; bus.IDMemWrite = 1'b0; bus.IDRegWrite = 1'b0; bus.IDImmd = 1'b0;
    bus.IDRegOp1 = '0; bus.IDRegOp2 = '0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pcwrite", 32'(bus.PCWrite), 0);
    chk("rst_ifidwrite", 32'(bus.IFIDWrite), 0);
    chk("rst_ifidflush", 32'(bus.IFIDFlush), 0);
    chk_regs();
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].st, tbl[i].br, tbl[i].v, tbl[i].ctrl, tbl[i].op1, tbl[i].op2);
      chk($sformatf("tbl%0d_pcw", i), 32'(c_pcw), 32'(tbl[i].exp_pcw));
      chk($sformatf("tbl%0d_flush", i), 32'(c_flush), 32'(tbl[i].exp_flush));
      chk($sformatf("tbl%0d_ctrl", i), 32'(dut_ctrl()), 32'(tbl[i].exp_ctrl));
      chk($sformatf("tbl%0d_op1", i), 32'(bus.IDEXRegOp1), 32'(tbl[i].exp_op1));
      chk($sformatf("tbl%0d_op2", i), 32'(bus.IDEXRegOp2), 32'(tbl[i].exp_op2));
      chk($sformatf("tbl%0d_scnt", i), 32'(bus.StallCount), perf(tbl[i].exp_scnt));
      chk($sformatf("tbl%0d_bcnt", i), 32'(bus.BubbleCount), perf(tbl[i].exp_bcnt));
    end

    // watchdog: 10 stall cycles, error on the 8th stall edge and sticky afterwards
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b0, 1'b1, 4'b0010, 4'd1, 4'd2);
      chk($sformatf("wdog_err_%0d", k), 32'(bus.StallErr), 32'(k >= 8));
      chk($sformatf("wdog_pcw_%0d", k), 32'(c_pcw), 0);
    end
    step(1'b0, 1'b0, 1'b1, 4'b0010, 4'd1, 4'd2);
    chk("wdog_sticky", 32'(bus.StallErr), 1);
    chk("wdog_scnt", 32'(bus.StallCount), perf(11));
    chk("wdog_bcnt", 32'(bus.BubbleCount), perf(13));

    // asynchronous reset in the middle of a stall
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 4'b1000, 4'd5, 4'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pcwrite", 32'(bus.PCWrite), 0);
    chk("arst_ifidwrite", 32'(bus.IFIDWrite), 0);
    chk("arst_ifidflush", 32'(bus.IFIDFlush), 0);
    chk("arst_ctrl", 32'(dut_ctrl()), 0);
    chk("arst_op1", 32'(bus.IDEXRegOp1), 0);
    chk("arst_op2", 32'(bus.IDEXRegOp2), 0);
    chk("arst_err", 32'(bus.StallErr), 0);
    chk("arst_scnt", 32'(bus.StallCount), 0);
    chk("arst_bcnt", 32'(bus.BubbleCount), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b0000, 4'd3, 4'd0);
    chk("post_rst_valid", 32'(bus.IDEXValid), 1);
    chk("post_rst_op1", 32'(bus.IDEXRegOp1), 3);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 11) == 0), 1'($urandom),
           4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
